// File: rtl/online_div_pkg.sv
// Shared definitions for the online divider: quotient digit encodings,
// converter state enum and default sizing.
package online_div_pkg;

    localparam logic [1:0] DIGIT_POS  = 2'b10;
    localparam logic [1:0] DIGIT_NEG  = 2'b01;
    localparam logic [1:0] DIGIT_ZERO = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } conv_state_t;

    localparam int unsigned DEFAULT_DIGITS    = 64;
    localparam int unsigned DEFAULT_CNT_WIDTH = 7;

endpackage

// File: rtl/otf_digit_append.sv
// Combinational on-the-fly conversion step: appends one signed digit to the
// Q/QM register pair. Illegal digit 2'b11 is converted as zero and flagged.
module otf_digit_append
    import online_div_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_DIGITS + 1
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] qm,
    input  logic [1:0]       digit,
    output logic [WIDTH-1:0] q_next,
    output logic [WIDTH-1:0] qm_next,
    output logic             illegal
);

    always_comb begin
        q_next  = {q[WIDTH-2:0], 1'b0};
        qm_next = {qm[WIDTH-2:0], 1'b1};
        illegal = 1'b0;
        case (digit)
            DIGIT_POS: begin
                q_next  = {q[WIDTH-2:0], 1'b1};
                qm_next = {q[WIDTH-2:0], 1'b0};
            end
            DIGIT_NEG: begin
                q_next  = {qm[WIDTH-2:0], 1'b1};
                qm_next = {qm[WIDTH-2:0], 1'b0};
            end
            DIGIT_ZERO: ;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/otf_quotient_converter.sv
// On-the-fly signed-digit to two's-complement quotient converter with a
// valid/ready result port. `define OTF_QM_OUT_EN to expose result_minus (final QM).
module otf_quotient_converter
    import online_div_pkg::*;
#(
    parameter int unsigned DIGITS    = DEFAULT_DIGITS,
    parameter int unsigned CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic              clk,
    input  logic              asyn_reset,
    input  logic              enable,
    input  logic              start,
    input  logic              digit_valid,
    input  logic [1:0]        q_value,
    output logic              busy,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [DIGITS:0]   result,
`ifdef OTF_QM_OUT_EN
    output logic [DIGITS:0]   result_minus,
`endif
    output logic              digit_err
);

    conv_state_t          state, state_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic [DIGITS:0]      q_reg, qm_reg;
    logic [DIGITS:0]      q_next, qm_next;
    logic                 illegal;
    logic                 accept;
    logic                 last_digit;

    assign accept       = enable && (state == ACCUM) && digit_valid;
    assign last_digit   = (cnt == CNT_WIDTH'(DIGITS - 1));
    assign busy         = (state == ACCUM);
    assign result_valid = (state == DONE);

    otf_digit_append #(
        .WIDTH(DIGITS + 1)
    ) u_digit_append (
        .q      (q_reg),
        .qm     (qm_reg),
        .digit  (q_value),
        .q_next (q_next),
        .qm_next(qm_next),
        .illegal(illegal)
    );

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (enable) begin
            case (state)
                IDLE:    if (start) state_next = ACCUM;
                ACCUM:   if (digit_valid && last_digit) state_next = DONE;
                DONE:    if (result_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            cnt       <= '0;
            q_reg     <= '0;
            qm_reg    <= '1;
            result    <= '0;
            digit_err <= 1'b0;
        end else if (enable) begin
            if ((state == IDLE) && start) begin
                cnt       <= '0;
                q_reg     <= '0;
                qm_reg    <= '1;
                digit_err <= 1'b0;
            end else if (accept) begin
                cnt    <= cnt + CNT_WIDTH'(1);
                q_reg  <= q_next;
                qm_reg <= qm_next;
                if (illegal) digit_err <= 1'b1;
                // Result is captured from the append outputs so it is valid
                // in the same cycle result_valid first shows.
                if (last_digit) result <= q_next;
            end
        end
    end

`ifdef OTF_QM_OUT_EN
    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            result_minus <= '1;
        end else if (enable && accept && last_digit) begin
            result_minus <= qm_next;
        end
    end
`endif

endmodule

// File: tb/tb_otf_quotient_converter.sv
// Self-checking bench: directed DIGITS=4 scenarios plus randomized DIGITS=64
// streams checked against an arithmetic sum of the signed digits.
module tb_otf_quotient_converter;

    logic clk = 1'b0;
    logic asyn_reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // DIGITS=4 instance
    logic       a_en, a_start, a_dv, a_ready;
    logic [1:0] a_q;
    logic       a_busy, a_rv, a_err;
    logic [4:0] a_res;
`ifdef OTF_QM_OUT_EN
    logic [4:0] a_resm;
`endif

    // DIGITS=64 instance
    logic        b_en, b_start, b_dv, b_ready;
    logic [1:0]  b_q;
    logic        b_busy, b_rv, b_err;
    logic [64:0] b_res;
`ifdef OTF_QM_OUT_EN
    logic [64:0] b_resm;
`endif

    otf_quotient_converter #(.DIGITS(4), .CNT_WIDTH(3)) dut4 (
        .clk(clk), .asyn_reset(asyn_reset), .enable(a_en), .start(a_start),
        .digit_valid(a_dv), .q_value(a_q), .busy(a_busy), .result_valid(a_rv),
        .result_ready(a_ready), .result(a_res),
`ifdef OTF_QM_OUT_EN
        .result_minus(a_resm),
`endif
        .digit_err(a_err)
    );

    otf_quotient_converter #(.DIGITS(64), .CNT_WIDTH(7)) dut64 (
        .clk(clk), .asyn_reset(asyn_reset), .enable(b_en), .start(b_start),
        .digit_valid(b_dv), .q_value(b_q), .busy(b_busy), .result_valid(b_rv),
        .result_ready(b_ready), .result(b_res),
`ifdef OTF_QM_OUT_EN
        .result_minus(b_resm),
`endif
        .digit_err(b_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a DIGITS=4 operation and feed four digits back to back (MSD first).
    task automatic run4(input logic [7:0] digs);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                checks++;
                if (a_rv !== 1'b0) begin
                    errors++;
                    $display("FAIL latency_early: result_valid=%b required 0", a_rv);
                end
            end
            a_dv = 1'b1;
            a_q  = digs[7-2*i -: 2];
            tick();
        end
        a_dv = 1'b0;
        a_q  = 2'b00;
    endtask

    task automatic handshake4();
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        checks++;
        if (a_rv !== 1'b0 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL handshake4: valid=%b busy=%b required 0 0", a_rv, a_busy);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (a_busy !== 1'b0 || a_rv !== 1'b0 || a_res !== 5'b0 || a_err !== 1'b0) begin
            errors++;
            $display("FAIL reset4: busy=%b valid=%b result=%b err=%b required 0 0 00000 0",
                     a_busy, a_rv, a_res, a_err);
        end
        checks++;
        if (b_busy !== 1'b0 || b_rv !== 1'b0 || b_res !== 65'b0 || b_err !== 1'b0) begin
            errors++;
            $display("FAIL reset64: busy=%b valid=%b result=%h err=%b required 0 0 0 0",
                     b_busy, b_rv, b_res, b_err);
        end
`ifdef OTF_QM_OUT_EN
        checks++;
        if (a_resm !== 5'b11111) begin
            errors++;
            $display("FAIL reset_minus: got %b required 11111", a_resm);
        end
`endif
    endtask

    task automatic test_patterns();
        logic [7:0] pat [4] = '{8'b10_00_01_10, 8'b01_01_01_01, 8'b10_10_10_10, 8'b00_00_00_00};
        logic [4:0] exp [4] = '{5'b00111, 5'b10001, 5'b01111, 5'b00000};
        for (int p = 0; p < 4; p++) begin
            run4(pat[p]);
            checks++;
            if (a_rv !== 1'b1 || a_busy !== 1'b0 || a_res !== exp[p]) begin
                errors++;
                $display("FAIL pattern%0d: valid=%b busy=%b result=%b required 1 0 %b",
                         p, a_rv, a_busy, a_res, exp[p]);
            end
`ifdef OTF_QM_OUT_EN
            checks++;
            if (a_resm !== exp[p] - 5'd1) begin
                errors++;
                $display("FAIL pattern%0d_minus: got %b required %b", p, a_resm, exp[p] - 5'd1);
            end
`endif
            handshake4();
        end
    endtask

    task automatic test_hold();
        run4(8'b10_10_00_01);
        for (int c = 0; c < 5; c++) begin
            a_dv = 1'b1;
            a_q  = 2'b10;
            tick();
            checks++;
            if (a_rv !== 1'b1 || a_res !== 5'b01011) begin
                errors++;
                $display("FAIL hold%0d: valid=%b result=%b required 1 01011", c, a_rv, a_res);
            end
        end
        a_dv = 1'b0;
        a_ready = 1'b1;
        a_start = 1'b1;
        tick();
        a_ready = 1'b0;
        a_start = 1'b0;
        checks++;
        if (a_rv !== 1'b0 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL ready_with_start: valid=%b busy=%b required 0 0", a_rv, a_busy);
        end
        tick();
        checks++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("FAIL no_restart: busy=%b required 0", a_busy);
        end
        run4(8'b00_00_00_10);
        checks++;
        if (a_rv !== 1'b1 || a_res !== 5'b00001) begin
            errors++;
            $display("FAIL after_hold: valid=%b result=%b required 1 00001", a_rv, a_res);
        end
        handshake4();
    endtask

    task automatic test_gaps();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        a_dv = 1'b1; a_q = 2'b10; tick();
        a_dv = 1'b1; a_q = 2'b00; tick();
        a_en = 1'b0;
        a_q  = 2'b10;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (a_busy !== 1'b1 || a_rv !== 1'b0) begin
                errors++;
                $display("FAIL stall%0d: busy=%b valid=%b required 1 0", c, a_busy, a_rv);
            end
        end
        a_en = 1'b1;
        a_dv = 1'b0;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        a_dv = 1'b1; a_q = 2'b01; tick();
        checks++;
        if (a_rv !== 1'b0 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL gap_count: valid=%b busy=%b required 0 1", a_rv, a_busy);
        end
        a_q = 2'b10; tick();
        a_dv = 1'b0;
        checks++;
        if (a_rv !== 1'b1 || a_res !== 5'b00111) begin
            errors++;
            $display("FAIL gap_result: valid=%b result=%b required 1 00111", a_rv, a_res);
        end
        handshake4();
    endtask

    task automatic test_illegal();
        run4(8'b10_11_00_00);
        checks++;
        if (a_err !== 1'b1 || a_res !== 5'b01000) begin
            errors++;
            $display("FAIL illegal: err=%b result=%b required 1 01000", a_err, a_res);
        end
        handshake4();
        checks++;
        if (a_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%b required 1", a_err);
        end
        a_dv = 1'b1;
        a_q  = 2'b10;
        tick();
        tick();
        a_dv = 1'b0;
        checks++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("FAIL dv_in_idle: busy=%b required 0", a_busy);
        end
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        checks++;
        if (a_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b required 0", a_err);
        end
        for (int i = 0; i < 4; i++) begin
            a_dv = 1'b1; a_q = 2'b00; tick();
        end
        a_dv = 1'b0;
        checks++;
        if (a_res !== 5'b00000 || a_rv !== 1'b1) begin
            errors++;
            $display("FAIL zero_after_idle_dv: result=%b valid=%b required 00000 1", a_res, a_rv);
        end
        handshake4();
    endtask

    task automatic test_reset_mid();
        run4(8'b10_11_10_10);
        handshake4();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        a_dv = 1'b1; a_q = 2'b10; tick();
        a_q = 2'b10; tick();
        a_dv = 1'b0;
        asyn_reset = 1'b1;
        #1;
        checks++;
        if (a_busy !== 1'b0 || a_rv !== 1'b0 || a_res !== 5'b0 || a_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b valid=%b result=%b err=%b required 0 0 00000 0",
                     a_busy, a_rv, a_res, a_err);
        end
        tick();
        asyn_reset = 1'b0;
        run4(8'b10_00_01_10);
        checks++;
        if (a_res !== 5'b00111 || a_rv !== 1'b1) begin
            errors++;
            $display("FAIL after_reset: result=%b valid=%b required 00111 1", a_res, a_rv);
        end
        handshake4();
    endtask

    task automatic test_random64();
        logic [66:0] acc;
        logic        err_exp;
        int          n;
        int          cycles;
        int          r;
        for (int op = 0; op < 12; op++) begin
            b_start = 1'b1;
            tick();
            b_start = 1'b0;
            checks++;
            if (b_busy !== 1'b1) begin
                errors++;
                $display("FAIL rnd%0d_start: busy=%b required 1", op, b_busy);
            end
            acc = '0;
            err_exp = 1'b0;
            n = 0;
            cycles = 0;
            while (n < 64 && cycles < 2000) begin
                b_en = ($urandom % 8) != 0;
                b_dv = ($urandom % 4) != 0;
                r = int'($urandom % 16);
                b_q = (r == 0) ? 2'b11 : 2'(r % 3);
                if (b_en && b_dv) begin
                    n++;
                    if (b_q == 2'b10)      acc = (acc << 1) + 67'd1;
                    else if (b_q == 2'b01) acc = (acc << 1) - 67'd1;
                    else                   acc = acc << 1;
                    if (b_q == 2'b11) err_exp = 1'b1;
                end
                tick();
                cycles++;
                if (n < 64) begin
                    checks++;
                    if (b_rv !== 1'b0) begin
                        errors++;
                        $display("FAIL rnd%0d_early_valid: valid=%b after %0d digits required 0",
                                 op, b_rv, n);
                    end
                end
            end
            b_en = 1'b1;
            b_dv = 1'b0;
            checks++;
            if (n < 64) begin
                errors++;
                $display("FAIL rnd%0d_timeout: accepted %0d digits required 64", op, n);
            end
            checks++;
            if (b_rv !== 1'b1 || b_res !== acc[64:0] || b_err !== err_exp) begin
                errors++;
                $display("FAIL rnd%0d_result: valid=%b result=%h err=%b required 1 %h %b",
                         op, b_rv, b_res, b_err, acc[64:0], err_exp);
            end
`ifdef OTF_QM_OUT_EN
            checks++;
            if (b_resm !== acc[64:0] - 65'd1) begin
                errors++;
                $display("FAIL rnd%0d_minus: got %h required %h", op, b_resm, acc[64:0] - 65'd1);
            end
`endif
            repeat ($urandom_range(0, 3)) tick();
            b_ready = 1'b1;
            tick();
            b_ready = 1'b0;
            checks++;
            if (b_rv !== 1'b0) begin
                errors++;
                $display("FAIL rnd%0d_handshake: valid=%b required 0", op, b_rv);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        asyn_reset = 1'b1;
        a_en = 1'b1; a_start = 1'b0; a_dv = 1'b0; a_ready = 1'b0; a_q = 2'b00;
        b_en = 1'b1; b_start = 1'b0; b_dv = 1'b0; b_ready = 1'b0; b_q = 2'b00;
        tick();
        test_reset();
        tick();
        asyn_reset = 1'b0;
        tick();
        test_patterns();
        test_hold();
        test_gaps();
        test_illegal();
        test_reset_mid();
        test_random64();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/otf_quotient_converter.md
Name: otf_quotient_converter

Overview:
- Consumes the signed-digit quotient stream from the online divider's digit-selection stage, one digit per accepted cycle, most significant digit first.
- Converts the stream to a conventional two's-complement fixed-point quotient on the fly, using a Q/QM register pair, so no carry-propagate adder is needed.
- Presents the finished quotient through a valid/ready handshake to the downstream consumer.

Parameters:
- DIGITS, 64, number of quotient digits per operation (matches divider unrolling).
- CNT_WIDTH, 7, digit counter width; must satisfy CNT_WIDTH >= clog2(DIGITS+1).

Ports:
- clk  input  1  clock, rising edge.
- asyn_reset  input  1  reset; asynchronous, active-high.
- enable  input  1  global stall; when low, no state, register or output changes.
- start  input  1  begin new conversion; accepted only in IDLE.
- digit_valid  input  1  q_value carries a digit this cycle.
- q_value  input  2  digit: 2'b10 = +1, 2'b01 = -1, 2'b00 = 0, 2'b11 = illegal.
- busy  output  1  high in ACCUM.
- result_valid  output  1  result holds a finished quotient.
- result_ready  input  1  downstream accepts result.
- result  output  DIGITS+1  two's-complement quotient: 1 sign bit and DIGITS fraction bits; value = result * 2^-DIGITS.
- digit_err  output  1  sticky; set when an illegal digit is accepted.

Behaviour:
- Reset: state IDLE, counter 0, Q 0, QM all ones, busy 0, result_valid 0, result 0, digit_err 0.
- All updates below occur only when enable=1.
- States:
  - IDLE: on start, load Q=0, QM=all ones (-1), counter=0, clear digit_err; go to ACCUM.
  - ACCUM: accept one digit per cycle with digit_valid. On the DIGITS-th accepted digit, go to DONE.
  - DONE: result_valid=1; result = Q, held stable. When result_ready=1, go to IDLE and drop result_valid the next cycle.
- Digit update, shifting left with the new bit at the LSB:
  - q=+1: Q={Q,1}, QM={Q,0}.
  - q=0: Q={Q,0}, QM={QM,1}.
  - q=-1: Q={QM,1}, QM={QM,0}.
  - Both registers are DIGITS+1 bits. Dropped MSBs are sign copies, because |value| < 1.
- Latency: result_valid rises on the clock edge that accepts the last digit, so it is visible the following cycle.
- Invariant: QM = Q - 1 LSB after every update.
- Boundary conditions:
  - Illegal digit 2'b11: treated as 0, sets digit_err, and still counts as a digit.
  - digit_valid in IDLE or DONE: ignored.
  - start in ACCUM or DONE: ignored; no restart.
  - start together with result_ready in DONE: handshake completes; start is ignored. A new start is needed in IDLE.
  - result_ready while result_valid=0: no effect.
  - enable low mid-ACCUM: digit is not accepted, counter frozen, state held.
  - asyn_reset mid-operation: immediate return to reset values; the partial quotient is lost.
- Arithmetic extremes: all +1 gives 1 - 2^-DIGITS (0111..1); all -1 gives -1 + 2^-DIGITS (1000..01). Neither overflows.

Optional Feature:
- Macro OTF_QM_OUT_EN.
- Defined: adds output result_minus [DIGITS:0] = final QM, i.e. result minus 1 LSB. Its timing, reset value (all ones) and hold behaviour match result. It is used by the downstream rounding/remainder-sign correction.
- Undefined: no port; QM stays internal.

Decomposition:
- Shared package online_div_pkg:
  - digit encodings DIGIT_POS=2'b10, DIGIT_NEG=2'b01, DIGIT_ZERO=2'b00;
  - state enum {IDLE, ACCUM, DONE};
  - default DIGITS and CNT_WIDTH constants.
- One natural sub-module: otf_digit_append, combinational. Inputs Q, QM and a digit; outputs next Q, next QM and an illegal-digit flag. The top block holds the FSM, counter, handshake and registers.

Test Plan (DIGITS=4 unless noted):
- Digits +1,0,-1,+1 -> result 5'b00111 (7/16); result_valid one cycle after 4th digit; with OTF_QM_OUT_EN, result_minus 5'b00110.
- Digits -1,-1,-1,-1 -> result 5'b10001 (-15/16); all +1 -> 5'b01111; all 0 -> 5'b00000.
- Hold result_ready=0 for 5 cycles in DONE -> result_valid and result stable; raise ready -> IDLE, next start accepted.
- Digits with digit_valid/enable gaps (e.g. enable low 3 cycles between digits 2 and 3) -> same result as gap-free run; counter frozen during gaps.
- Digit 2'b11 as 2nd of +1,11,0,0 -> digit_err=1, result 5'b01000; next start clears digit_err.
- asyn_reset after 2 digits -> outputs at reset values immediately; start in ACCUM ignored; DIGITS=64 random streams checked against a reference sum of q_i*2^-i.
